// File: rtl/khu_sensor_pkg.sv
// khu_sensor shared definitions: UART frame tags,
// stream control codes and TX arbiter state encoding.
package khu_sensor_pkg;

  localparam logic [7:0] UART_SG_RUN  = 8'h52;
  localparam logic [7:0] UART_SG_STOP = 8'h53;

  localparam logic [7:0] UART_TAG_ADS = 8'h41;
  localparam logic [7:0] UART_TAG_MPR = 8'h4D;

  localparam int ADS_W   = 40;
  localparam int MPR_W   = 16;
  localparam int FRAME_W = 48;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic logic [FRAME_W-1:0] ads_frame(
    input logic [ADS_W-1:0] d
  );
    return {UART_TAG_ADS, d};
  endfunction

  function automatic logic [FRAME_W-1:0] mpr_frame(
    input logic [MPR_W-1:0] d
  );
    return {UART_TAG_MPR, d, 24'h0};
  endfunction

endpackage

// File: rtl/tx_src_slot.sv
// One-entry holding slot between a sensor source
// and the shared UART TX arbiter.
module tx_src_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic [W-1:0] o_data,
  input  logic         i_clr,
  input  logic         i_flush
);

  logic         full_q;
  logic         full_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         load;

  assign o_ready = ~full_q & i_en;
  assign load    = i_valid & o_ready;
  assign o_full  = full_q;
  assign o_data  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = i_data;
    end
    // clear never meets a load: ready is low while full
    if (i_clr | i_flush) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX path between the ADS1292 sample
// stream and the MPR121 touch stream (ADS priority, MPR bounded wait).
module uart_tx_arbiter
  import khu_sensor_pkg::*;
#(
  parameter int MPR_MAX_WAIT = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic         i_CLK,
  input  logic         i_RSTN,
  input  logic         i_STREAM_EN,
  input  logic [39:0]  i_ADS_DATA,
  input  logic         i_ADS_VALID,
  output logic         o_ADS_READY,
  input  logic [15:0]  i_MPR_DATA,
  input  logic         i_MPR_VALID,
  output logic         o_MPR_READY,
  output logic [47:0]  o_UART_DATA_TX,
  output logic         o_UART_DATA_TX_VALID,
  input  logic         i_UART_DATA_TX_READY,
  output logic [15:0]  o_ADS_FRAME_CNT,
  output logic [15:0]  o_MPR_FRAME_CNT,
  output logic         o_BUSY
);

  localparam logic [3:0] MAX_WAIT = 4'(MPR_MAX_WAIT);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [3:0]  gap_q;
  logic [3:0]  gap_d;
  logic [3:0]  wait_q;
  logic [3:0]  wait_d;
  logic        sel_mpr_q;
  logic        sel_mpr_d;
  logic [47:0] tx_data_q;
  logic [47:0] tx_data_d;
  logic        tx_valid_q;
  logic        tx_valid_d;
  logic [15:0] ads_cnt_q;
  logic [15:0] ads_cnt_d;
  logic [15:0] mpr_cnt_q;
  logic [15:0] mpr_cnt_d;

  logic        ads_full;
  logic        mpr_full;
  logic [39:0] ads_data;
  logic [15:0] mpr_data;

  logic        idle;
  logic        flush;
  logic        pick_ads;
  logic        pick_mpr;
  logic        uart_xfer;
  logic        sent_ads;
  logic        sent_mpr;

  tx_src_slot #(
    .W (40)
  ) u_ads_slot (
    .clk     (i_CLK),
    .rst_n   (i_RSTN),
    .i_en    (i_STREAM_EN),
    .i_valid (i_ADS_VALID),
    .o_ready (o_ADS_READY),
    .i_data  (i_ADS_DATA),
    .o_full  (ads_full),
    .o_data  (ads_data),
    .i_clr   (sent_ads),
    .i_flush (flush)
  );

  tx_src_slot #(
    .W (16)
  ) u_mpr_slot (
    .clk     (i_CLK),
    .rst_n   (i_RSTN),
    .i_en    (i_STREAM_EN),
    .i_valid (i_MPR_VALID),
    .o_ready (o_MPR_READY),
    .i_data  (i_MPR_DATA),
    .o_full  (mpr_full),
    .o_data  (mpr_data),
    .i_clr   (sent_mpr),
    .i_flush (flush)
  );

  assign idle  = (state_q == ST_IDLE);
  assign flush = idle & ~i_STREAM_EN;

  // MPR only loses to ADS until it has waited MAX_WAIT grants
  assign pick_ads = idle & i_STREAM_EN & ads_full &
                    (~mpr_full | (wait_q < MAX_WAIT));
  assign pick_mpr = idle & i_STREAM_EN & mpr_full & ~pick_ads;

  assign uart_xfer = (state_q == ST_SEND) & tx_valid_q &
                     i_UART_DATA_TX_READY;
  assign sent_ads  = uart_xfer & ~sel_mpr_q;
  assign sent_mpr  = uart_xfer & sel_mpr_q;

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      wait_q     <= '0;
      sel_mpr_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ads_cnt_q  <= '0;
      mpr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wait_q     <= wait_d;
      sel_mpr_q  <= sel_mpr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ads_cnt_q  <= ads_cnt_d;
      mpr_cnt_q  <= mpr_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_ads | pick_mpr) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (uart_xfer) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    sel_mpr_d  = sel_mpr_q;
    ads_cnt_d  = ads_cnt_q;
    mpr_cnt_d  = mpr_cnt_q;
    wait_d     = wait_q;

    unique case (1'b1)
      pick_ads: begin
        tx_data_d  = ads_frame(ads_data);
        tx_valid_d = 1'b1;
        sel_mpr_d  = 1'b0;
      end
      pick_mpr: begin
        tx_data_d  = mpr_frame(mpr_data);
        tx_valid_d = 1'b1;
        sel_mpr_d  = 1'b1;
      end
      default: ;
    endcase

    if (uart_xfer) begin
      tx_valid_d = 1'b0;
    end
    if (sent_ads) begin
      ads_cnt_d = ads_cnt_q + 16'd1;
    end
    if (sent_mpr) begin
      mpr_cnt_d = mpr_cnt_q + 16'd1;
    end

    if (sent_mpr | ~mpr_full | flush) begin
      wait_d = '0;
    end else if (sent_ads & (wait_q != 4'hF)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  assign o_UART_DATA_TX       = tx_data_q;
  assign o_UART_DATA_TX_VALID = tx_valid_q;
  assign o_ADS_FRAME_CNT      = ads_cnt_q;
  assign o_MPR_FRAME_CNT      = mpr_cnt_q;
  assign o_BUSY = ~idle | ads_full | mpr_full;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector bench for uart_tx_arbiter:
// single frames, backpressure, bounded wait, stream stop, reset, wrap.
module tb_uart_tx_arbiter;

  localparam int GAP = 2;

  logic        clk;
  logic        rstn;
  logic        stream_en;
  logic [39:0] ads_data;
  logic        ads_valid;
  logic        ads_ready;
  logic [15:0] mpr_data;
  logic        mpr_valid;
  logic        mpr_ready;
  logic [47:0] tx_data;
  logic        tx_valid;
  logic        uart_ready;
  logic [15:0] ads_cnt;
  logic [15:0] mpr_cnt;
  logic        busy;

  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] ads_exp;
  logic [15:0] mpr_exp;

  uart_tx_arbiter #(
    .MPR_MAX_WAIT (4),
    .GAP_CYCLES   (GAP)
  ) dut (
    .i_CLK                (clk),
    .i_RSTN               (rstn),
    .i_STREAM_EN          (stream_en),
    .i_ADS_DATA           (ads_data),
    .i_ADS_VALID          (ads_valid),
    .o_ADS_READY          (ads_ready),
    .i_MPR_DATA           (mpr_data),
    .i_MPR_VALID          (mpr_valid),
    .o_MPR_READY          (mpr_ready),
    .o_UART_DATA_TX       (tx_data),
    .o_UART_DATA_TX_VALID (tx_valid),
    .i_UART_DATA_TX_READY (uart_ready),
    .o_ADS_FRAME_CNT      (ads_cnt),
    .o_MPR_FRAME_CNT      (mpr_cnt),
    .o_BUSY               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_mpr;
    logic [39:0] ads;
    logic [15:0] mpr;
    logic [47:0] frame;
  } vec_t;

  vec_t tbl[6];

  function automatic void chk(
    input string       nm,
    input logic [47:0] act,
    input logic [47:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("src_ready", v.is_mpr ? mpr_ready : ads_ready, 1);
    if (v.is_mpr) begin
      mpr_data  = v.mpr;
      mpr_valid = 1'b1;
    end else begin
      ads_data  = v.ads;
      ads_valid = 1'b1;
    end
    @(negedge clk);
    ads_valid = 1'b0;
    mpr_valid = 1'b0;
    chk("lat1_valid", tx_valid, 0);
    chk("lat1_busy", busy, 1);
    @(negedge clk);
    chk("lat2_valid", tx_valid, 1);
    chk("frame", tx_data, v.frame);
    @(negedge clk);
    if (v.is_mpr) mpr_exp = mpr_exp + 16'd1;
    else ads_exp = ads_exp + 16'd1;
    chk("post_valid", tx_valid, 0);
    chk("ads_cnt", ads_cnt, ads_exp);
    chk("mpr_cnt", mpr_cnt, mpr_exp);
    repeat (GAP) @(negedge clk);
    chk("idle_busy", busy, 0);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn    = 1'b1;
    ads_exp = '0;
    mpr_exp = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  tags[$];
    logic [7:0]  bw_exp[7];
    logic [47:0] held;
    int          cyc;

    tbl[0] = '{1'b0, 40'h01_2345_6789, 16'h0, 48'h41_01_2345_6789};
    tbl[1] = '{1'b1, 40'h0, 16'hA5C3, 48'h4D_A5C3_000000};
    tbl[2] = '{1'b0, 40'hFF_FFFF_FFFF, 16'h0, 48'h41_FF_FFFF_FFFF};
    tbl[3] = '{1'b1, 40'h0, 16'h0001, 48'h4D_0001_000000};
    tbl[4] = '{1'b0, 40'h00_0000_0000, 16'h0, 48'h41_00_0000_0000};
    tbl[5] = '{1'b1, 40'h0, 16'hFFFF, 48'h4D_FFFF_000000};
    bw_exp = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h4D, 8'h41, 8'h41};

    rstn       = 1'b0;
    stream_en  = 1'b0;
    ads_data   = '0;
    ads_valid  = 1'b0;
    mpr_data   = '0;
    mpr_valid  = 1'b0;
    uart_ready = 1'b1;
    ads_exp    = '0;
    mpr_exp    = '0;

    #3;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 48'h0);
    chk("rst_ads_cnt", ads_cnt, 0);
    chk("rst_mpr_cnt", mpr_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_off", ads_ready, 0);
    stream_en = 1'b1;
    #1;
    chk("rst_ready_on", mpr_ready, 1);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i]);
    end

    // backpressure: hold for 10 cycles, then accept once
    uart_ready = 1'b0;
    @(negedge clk);
    ads_data  = 40'hDE_ADBE_EF01;
    ads_valid = 1'b1;
    @(negedge clk);
    ads_valid = 1'b0;
    @(negedge clk);
    held = 48'h41_DE_ADBE_EF01;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", tx_valid, 1);
      chk("bp_data", tx_data, held);
      @(negedge clk);
    end
    uart_ready = 1'b1;
    @(negedge clk);
    ads_exp = ads_exp + 16'd1;
    chk("bp_done_valid", tx_valid, 0);
    chk("bp_cnt", ads_cnt, ads_exp);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_nodup", tx_valid, 0);
    end
    chk("bp_cnt_hold", ads_cnt, ads_exp);

    // bounded wait: ADS streams, MPR offers one frame
    @(negedge clk);
    ads_data  = 40'h11_1111_1111;
    ads_valid = 1'b1;
    mpr_data  = 16'h1234;
    mpr_valid = 1'b1;
    cyc = 0;
    while (tags.size() < 7 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (mpr_valid && !mpr_ready) mpr_valid = 1'b0;
      if (tx_valid) tags.push_back(tx_data[47:40]);
    end
    ads_valid = 1'b0;
    mpr_valid = 1'b0;
    chk("bw_frames", tags.size(), 7);
    for (int i = 0; i < 7 && i < tags.size(); i++) begin
      chk("bw_tag", tags[i], bw_exp[i]);
    end
    repeat (20) @(negedge clk);
    apply_reset();

    // stream disable during an ADS send with MPR queued
    uart_ready = 1'b0;
    @(negedge clk);
    ads_data  = 40'h22_3344_5566;
    ads_valid = 1'b1;
    mpr_data  = 16'hBEEF;
    mpr_valid = 1'b1;
    @(negedge clk);
    ads_valid = 1'b0;
    mpr_valid = 1'b0;
    @(negedge clk);
    chk("sd_valid", tx_valid, 1);
    chk("sd_frame", tx_data, 48'h41_22_3344_5566);
    stream_en  = 1'b0;
    uart_ready = 1'b1;
    @(negedge clk);
    chk("sd_done_valid", tx_valid, 0);
    chk("sd_ads_cnt", ads_cnt, 1);
    repeat (GAP + 2) @(negedge clk);
    chk("sd_busy", busy, 0);
    chk("sd_ads_ready", ads_ready, 0);
    chk("sd_mpr_ready", mpr_ready, 0);
    stream_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("sd_no_mpr", tx_valid, 0);
    chk("sd_mpr_cnt", mpr_cnt, 0);
    chk("sd_mpr_ready_on", mpr_ready, 1);

    // reset mid-send
    uart_ready = 1'b0;
    ads_data  = 40'h33_0000_0033;
    ads_valid = 1'b1;
    @(negedge clk);
    ads_valid = 1'b0;
    @(negedge clk);
    chk("rs_valid_pre", tx_valid, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rs_valid", tx_valid, 0);
    chk("rs_ads_cnt", ads_cnt, 0);
    chk("rs_busy", busy, 0);
    chk("rs_ready", ads_ready, 1);
    @(negedge clk);
    rstn       = 1'b1;
    uart_ready = 1'b1;
    ads_exp    = '0;
    mpr_exp    = '0;
    repeat (3) @(negedge clk);
    chk("rs_no_partial", tx_valid, 0);

    // frame counter wrap
    @(negedge clk);
    force dut.ads_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.ads_cnt_q;
    chk("wrap_preload", ads_cnt, 16'hFFFF);
    ads_exp = 16'hFFFF;
    run_vec(tbl[0]);
    chk("wrap_zero", ads_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART TX path between the ADS1292 sample stream and the MPR121 touch stream. Each source gets a one-entry holding slot. A tagged 48-bit frame is built and handed to the UART controller's TX valid/ready interface. ADS1292 has priority; a bounded-wait rule guarantees MPR121 progress. The block sits between the sensor cores and the UART controller.

## Interface
- MPR_MAX_WAIT, 4: consecutive ADS grants while MPR is pending before MPR is forced to win (1..15).
- GAP_CYCLES, 2: idle cycles inserted after each accepted frame (0..15).
- i_CLK  in  1  single clock.
- i_RSTN  in  1  reset, asynchronous, active-low.
- i_STREAM_EN  in  1  high = streaming allowed; low = stop capture and flush slots.
- i_ADS_DATA  in  40  ADS1292 payload.
- i_ADS_VALID  in  1  ADS payload valid.
- o_ADS_READY  out  1  ADS slot empty and stream enabled.
- i_MPR_DATA  in  16  MPR121 touch status.
- i_MPR_VALID  in  1  MPR payload valid.
- o_MPR_READY  out  1  MPR slot empty and stream enabled.
- o_UART_DATA_TX  out  48  frame to UART controller.
- o_UART_DATA_TX_VALID  out  1  frame valid.
- i_UART_DATA_TX_READY  in  1  UART controller ready.
- o_ADS_FRAME_CNT  out  16  ADS frames delivered, wraps.
- o_MPR_FRAME_CNT  out  16  MPR frames delivered, wraps.
- o_BUSY  out  1  high when state is not ST_IDLE or any slot is full.

## Operation
- **Transfer rule.** A transfer occurs on any rising edge where valid and ready are both high, on every interface.
- **Slots.**
  - Each slot loads on a source transfer.
  - o_*_READY = slot empty AND i_STREAM_EN.
  - A slot clears when its frame is accepted by the UART controller.
- **Frame format.**
  - ADS frame: {8'h41 ('A'), i_ADS_DATA[39:0]}.
  - MPR frame: {8'h4D ('M'), i_MPR_DATA[15:0], 24'h0}.
  - The tag is always in bits [47:40].
- **ST_IDLE.**
  - If the ADS slot is full and (MPR slot empty OR wait_cnt < MPR_MAX_WAIT): grant ADS.
  - Else if the MPR slot is full: grant MPR.
  - On a grant: load o_UART_DATA_TX, set valid, go to ST_SEND.
- **ST_SEND.**
  - Hold data and valid stable until ready.
  - On transfer: drop valid, clear the granted slot, increment that source's frame count, update wait_cnt, then go to ST_GAP (GAP_CYCLES>0) or ST_IDLE.
- **ST_GAP.** Count GAP_CYCLES cycles, then go to ST_IDLE.
- **wait_cnt (4 bits).**
  - Increments on an ADS transfer while the MPR slot is full; saturates at 15.
  - Clears on an MPR transfer.
  - Clears whenever the MPR slot is empty.
- **Stream disable.** While i_STREAM_EN is low:
  - No captures.
  - In ST_IDLE, both slots clear and wait_cnt clears.
  - A frame already in ST_SEND completes normally, then ST_GAP, then ST_IDLE, where the remaining slot is flushed.
- **Simultaneous events.**
  - Slot clear and source capture for the same source in one cycle cannot occur, because ready is low while the slot is full.
  - Both slots full with wait_cnt >= MPR_MAX_WAIT: MPR wins.
- **Counters.** 16-bit unsigned, wrap 16'hFFFF -> 16'h0000.
- **Reset values.**
  - Slots empty; state ST_IDLE; wait_cnt 0.
  - o_UART_DATA_TX 48'h0; o_UART_DATA_TX_VALID 0.
  - o_ADS_READY and o_MPR_READY follow i_STREAM_EN.
  - Counts 0; o_BUSY 0.
  - Reset mid-frame aborts immediately; no partial frame is kept.

## Timing
- Source transfer at edge N: slot full from N. The arbiter grants at edge N+1, so o_UART_DATA_TX_VALID is high after N+1. Latency is 2 clocks if ST_IDLE with no competitor.
- UART accepts at edge M:
  - Valid is low after M and the slot is empty after M.
  - Source ready rises after M (combinational from the slot flag), so the source can refill at edge M+1.
- Next grant at edge M+1+GAP_CYCLES (GAP_CYCLES=0: M+1).
- Minimum frame period: 2+GAP_CYCLES clocks with ready held high.
- Outputs o_UART_DATA_TX and valid are registered. o_*_READY are combinational from the slot flag and i_STREAM_EN only.

## Structure
- Shared package (khu_sensor_pkg):
  - Tag constants UART_TAG_ADS=8'h41 and UART_TAG_MPR=8'h4D, alongside the existing UART_SG_RUN/UART_SG_STOP.
  - State encoding ST_IDLE/ST_SEND/ST_GAP as 2-bit localparams.
- Sub-module tx_src_slot:
  - Parameter W.
  - Ports: valid/ready/data in, full, data out, clr, flush.
  - Instantiated twice (W=40, W=16).
- Arbiter FSM, wait counter, gap counter and frame counters live in the top.

## Test plan
- **Single ADS frame.** ADS valid with 40'h01_2345_6789, UART ready high → frame 48'h41_0123456789 valid 2 clocks after the source transfer. o_ADS_FRAME_CNT=1.
- **Single MPR frame.** MPR 16'hA5C3 → frame 48'h4D_A5C3_000000; o_MPR_FRAME_CNT=1.
- **Backpressure.** UART ready held low 10 cycles → frame and valid stable for all 10 cycles. Transfer on the first ready-high edge; no duplicate frame.
- **Bounded wait.** ADS continuously valid, MPR valid once, MPR_MAX_WAIT=4 → exactly 4 ADS frames, then the MPR frame, then ADS resumes.
- **Stream disable.** Both slots full, drop i_STREAM_EN during ST_SEND of ADS → the ADS frame completes. The MPR slot is flushed; o_MPR_FRAME_CNT unchanged; o_*_READY low.
- **Reset and wrap.** Assert i_RSTN low mid-ST_SEND → valid low asynchronously, all counts 0. Separately, preload o_ADS_FRAME_CNT to 16'hFFFF via 65535 frames (or force) → the next frame reads 16'h0000.
